// File: rtl/mcu_spi_pkg.sv
// Package shared by the MCU SPI bridge files.
// Holds the frame FSM state encoding, the opcode field positions,
// the read-response window length and a small opcode decode helper.
package mcu_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OPCODE = 3'd1,
      ST_WRITE  = 3'd2,
      ST_DUMMY  = 3'd3,
      ST_READ   = 3'd4
   } state_t;

   // Opcode byte layout: bit 7 selects read (1) / write (0), the low bits
   // carry the starting register address.
   localparam int OP_RW_BIT   = 7;
   localparam int OP_ADDR_LSB = 0;

   // Cycles after rd_en during which rd_valid is still accepted.
   localparam int RD_WINDOW = 48;
   localparam int WIN_W     = 6;

   function automatic logic is_read_op(input logic [7:0] op);
      return op[OP_RW_BIT];
   endfunction

endpackage

// File: rtl/mcu_spi_sync.sv
// Single-bit synchronizer with edge detection on the synchronized level.
// Ports:
//   clk, rst    : system clock, async active-high reset
//   raw         : asynchronous input
//   level       : synchronized level (STAGES flops deep)
//   rise, fall  : one-cycle pulses on synchronized edges
// The chain and the edge-detect history reset to RST_VAL, the line's idle level.
module mcu_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], raw};
         prev  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/mcu_spi_bridge.sv
// SPI (mode 0) slave bridging an MCU onto a simple register bus.
// Frame: opcode byte (bit7 = read, low bits = address), then either write
// data bytes, or one dummy byte followed by read data bytes. Address
// auto-increments per byte and wraps.
// Ports:
//   clk_50mhz, rst           : system clock, async active-high reset
//   spi_sck/cs_n/mosi/miso   : MCU SPI pins (inputs are asynchronous)
//   wr_en, addr, wr_data     : one-cycle register write strobe
//   rd_en, addr              : one-cycle register read request
//   rd_valid, rd_data        : read response strobe and data
module mcu_spi_bridge
   import mcu_spi_pkg::*;
#(
   parameter int ADDR_WIDTH  = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_50mhz,
   input  logic                  rst,
   input  logic                  spi_sck,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [7:0]            wr_data,
   input  logic                  rd_valid,
   input  logic [7:0]            rd_data
);

   localparam int             SW       = $clog2(SYNC_STAGES + 1);
   localparam logic [SW-1:0]  SETTLE   = SW'(SYNC_STAGES);
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(RD_WINDOW + 1);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   mcu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk_50mhz), .rst(rst), .raw(spi_sck),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));

   mcu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk_50mhz), .rst(rst), .raw(spi_cs_n),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

   mcu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk_50mhz), .rst(rst), .raw(spi_mosi),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

   logic unused_ok;
   assign unused_ok = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

   state_t            state, state_nx;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg_in;
   logic [7:0]        shreg_out;
   logic [7:0]        rd_buf;
   logic              miso_q;
   logic [WIN_W-1:0]  win;
   logic [SW-1:0]     settle;
   logic              armed;
   logic              frame_start;
   logic              byte_done;
   logic [7:0]        in_byte;

   // The CS synchronizer resets to "deselected". If the MCU still holds CS
   // low when reset releases, the chain would flush to 0 and fake a falling
   // edge mid-frame. Only accept a frame start once CS has been seen high
   // after the chain has filled with real samples.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         settle <= '0;
         armed  <= 1'b0;
      end else if (settle != SETTLE) begin
         settle <= settle + 1'b1;
      end else if (cs_lvl) begin
         armed <= 1'b1;
      end
   end

   assign frame_start = cs_fall & armed;
   assign in_byte     = {shreg_in[6:0], mosi_lvl};
   assign byte_done   = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (cs_rise) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (frame_start) state_nx = ST_OPCODE;
            ST_OPCODE: if (byte_done)
                          state_nx = is_read_op(in_byte) ? ST_DUMMY : ST_WRITE;
            ST_DUMMY:  if (byte_done) state_nx = ST_READ;
            ST_WRITE, ST_READ: ;
            default:   state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         addr      <= '0;
         wr_data   <= '0;
         bit_cnt   <= '0;
         shreg_in  <= '0;
         shreg_out <= '0;
         rd_buf    <= '0;
         miso_q    <= 1'b0;
         win       <= '0;
      end else begin
         wr_en <= 1'b0;
         rd_en <= 1'b0;
         // Address advances once the write strobe has been presented.
         if (wr_en)       addr <= addr + 1'b1;
         if (win != '0)   win  <= win - 1'b1;
         if (state != ST_READ) miso_q <= 1'b0;

         // Late or unsolicited responses are dropped.
         if (rd_valid && (win != '0) && (state != ST_IDLE)) rd_buf <= rd_data;

         if (state == ST_IDLE) begin
            bit_cnt <= '0;
            win     <= '0;
         end else if (!cs_rise) begin
            if (sck_rise) begin
               shreg_in <= in_byte;
               bit_cnt  <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
               case (state)
                  ST_OPCODE: begin
                     addr <= in_byte[OP_ADDR_LSB +: ADDR_WIDTH];
                     if (is_read_op(in_byte)) begin
                        rd_en  <= 1'b1;
                        win    <= WIN_LOAD;
                        rd_buf <= '0;
                     end
                  end
                  ST_WRITE: begin
                     wr_en   <= 1'b1;
                     wr_data <= in_byte;
                  end
                  ST_READ: begin
                     // Prefetch the next byte while the MCU finishes this one.
                     addr   <= addr + 1'b1;
                     rd_en  <= 1'b1;
                     win    <= WIN_LOAD;
                     rd_buf <= '0;
                  end
                  default: ;
               endcase
            end

            // First falling edge of each read byte loads the response buffer;
            // the rest shift it out MSB first.
            if (sck_fall && (state == ST_READ)) begin
               if (bit_cnt == 3'd0) begin
                  miso_q    <= rd_buf[7];
                  shreg_out <= {rd_buf[6:0], 1'b0};
               end else begin
                  miso_q    <= shreg_out[7];
                  shreg_out <= {shreg_out[6:0], 1'b0};
               end
            end
         end
      end
   end

   assign spi_miso = (state == ST_READ) ? miso_q : 1'b0;

endmodule

// File: tb/tb_mcu_spi_bridge.sv
// Self-checking bench for mcu_spi_bridge: table of write/read frames plus
// hand-written abort and reset sequences, strobes checked via scoreboard.
module tb_mcu_spi_bridge;
   import mcu_spi_pkg::*;

   localparam int HALF = 12;

   logic       clk_50mhz = 1'b0;
   logic       rst = 1'b1;
   logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   logic       spi_miso, wr_en, rd_en;
   logic [6:0] addr;
   logic [7:0] wr_data;
   logic       rd_valid;
   logic [7:0] rd_data;

   always #10 clk_50mhz = ~clk_50mhz;

   mcu_spi_bridge #(.ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
      .clk_50mhz(clk_50mhz), .rst(rst),
      .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data));

   // Register model: answers each rd_en a few cycles later when enabled.
   logic [7:0] mem [0:127];
   logic       resp_on = 1'b0;
   logic       inj_valid = 1'b0;
   logic [7:0] inj_data = 8'h00;
   logic [2:0] rcnt = '0;
   logic [6:0] raddr = '0;

   always @(posedge clk_50mhz) begin
      if (rd_en) begin
         rcnt  <= 3'd4;
         raddr <= addr;
      end else if (rcnt != 0) begin
         rcnt <= rcnt - 3'd1;
      end
      rd_valid <= (resp_on && rcnt == 3'd1) || inj_valid;
      rd_data  <= inj_valid ? inj_data : mem[raddr];
   end

   // Observed strobes.
   logic [15:0] obs_wr [$];
   logic [7:0]  obs_rd [$];
   int          overlap = 0;

   always @(negedge clk_50mhz) begin
      if (wr_en) obs_wr.push_back({1'b0, addr, wr_data});
      if (rd_en) obs_rd.push_back({1'b0, addr});
      if (wr_en && rd_en) overlap++;
   end

   logic [15:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   int n_tests = 0, n_fail = 0;

   task automatic tick();
      @(posedge clk_50mhz);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drain(input string tag);
      logic [15:0] ew;
      logic [7:0]  er;
      while (exp_wr.size() > 0) begin
         ew = exp_wr.pop_front();
         if (obs_wr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s wr: strobe missing, expected addr/data %h", tag, ew);
         end else chk({tag, " wr addr/data"}, 32'(obs_wr.pop_front()), 32'(ew));
      end
      chk({tag, " extra wr strobes"}, obs_wr.size(), 0);
      obs_wr.delete();
      while (exp_rd.size() > 0) begin
         er = exp_rd.pop_front();
         if (obs_rd.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s rd: strobe missing, expected addr %h", tag, er);
         end else chk({tag, " rd addr"}, 32'(obs_rd.pop_front()), 32'(er));
      end
      chk({tag, " extra rd strobes"}, obs_rd.size(), 0);
      obs_rd.delete();
   endtask

   // MCU side, mode 0: MOSI set while SCK low, both sides sample on the rise.
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = tx[i];
         repeat (HALF) tick();
         rx[i] = spi_miso;
         spi_sck = 1'b1;
         repeat (HALF) tick();
         spi_sck = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] op, input int nb, input logic [7:0] b0, b1,
                        output logic [7:0] r_op, r_dm, r0, r1);
      r_dm = 8'h00; r1 = 8'h00;
      spi_cs_n = 1'b0;
      repeat (HALF) tick();
      spi_bits(op, 8, r_op);
      if (op[7]) spi_bits(8'h00, 8, r_dm);
      spi_bits(b0, 8, r0);
      if (nb > 1) spi_bits(b1, 8, r1);
      repeat (HALF) tick();
      spi_cs_n = 1'b1;
      repeat (60) tick();
   endtask

   typedef struct {
      logic [7:0] op, b0, b1;
      logic       resp;
      logic [7:0] ea0, ea1, ea2;   // expected strobe addresses
      logic [7:0] ed0, ed1;        // expected write data / MISO bytes
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [7:0] r_op, r_dm, r0, r1;

      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h33;

      vecs[0] = '{8'h05, 8'hA5, 8'h3C, 1'b0, 8'h05, 8'h06, 8'h00, 8'hA5, 8'h3C};
      vecs[1] = '{8'h7F, 8'h5A, 8'h6B, 1'b0, 8'h7F, 8'h00, 8'h00, 8'h5A, 8'h6B};
      vecs[2] = '{8'h82, 8'h00, 8'h00, 1'b1, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22};
      vecs[3] = '{8'h85, 8'h00, 8'h00, 1'b0, 8'h05, 8'h06, 8'h07, 8'h00, 8'h00};
      vecs[4] = '{8'h03, 8'hC3, 8'h81, 1'b0, 8'h03, 8'h04, 8'h00, 8'hC3, 8'h81};

      // Reset state.
      repeat (4) tick();
      chk("reset wr_en", wr_en, 0);
      chk("reset rd_en", rd_en, 0);
      chk("reset addr", addr, 0);
      chk("reset wr_data", wr_data, 0);
      chk("reset miso", spi_miso, 0);
      chk("reset state", 32'(dut.state), 32'(ST_IDLE));
      rst = 1'b0;
      repeat (10) tick();

      // A response strobe while idle must not be captured.
      inj_data = 8'hEE; inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      repeat (5) tick();
      chk("idle rd_valid ignored", dut.rd_buf, 0);

      for (int v = 0; v < 5; v++) begin
         resp_on = vecs[v].resp;
         if (vecs[v].op[7]) begin
            // Opcode fetch, then one prefetch per completed data byte.
            exp_rd.push_back(vecs[v].ea0);
            exp_rd.push_back(vecs[v].ea1);
            exp_rd.push_back(vecs[v].ea2);
         end else begin
            exp_wr.push_back({vecs[v].ea0, vecs[v].ed0});
            exp_wr.push_back({vecs[v].ea1, vecs[v].ed1});
         end
         frame(vecs[v].op, 2, vecs[v].b0, vecs[v].b1, r_op, r_dm, r0, r1);
         chk($sformatf("vec%0d miso during opcode", v), r_op, 0);
         if (vecs[v].op[7]) begin
            chk($sformatf("vec%0d miso during dummy", v), r_dm, 0);
            chk($sformatf("vec%0d read byte0", v), r0, vecs[v].ed0);
            chk($sformatf("vec%0d read byte1", v), r1, vecs[v].ed1);
         end
         drain($sformatf("vec%0d", v));
         chk($sformatf("vec%0d state idle", v), 32'(dut.state), 32'(ST_IDLE));
      end
      resp_on = 1'b0;

      // CS released 5 bits into a data byte: no strobe.
      spi_cs_n = 1'b0;
      repeat (HALF) tick();
      spi_bits(8'h20, 8, r_op);
      spi_bits(8'hFF, 5, r0);
      repeat (HALF) tick();
      spi_cs_n = 1'b1;
      repeat (60) tick();
      drain("partial");
      chk("partial state idle", 32'(dut.state), 32'(ST_IDLE));

      // Reset mid-byte with CS held low; traffic after release must be
      // ignored until CS goes high and falls again.
      spi_cs_n = 1'b0;
      repeat (HALF) tick();
      spi_bits(8'h30, 8, r_op);
      spi_bits(8'hAA, 4, r0);
      rst = 1'b1;
      repeat (3) tick();
      chk("mid-frame rst state", 32'(dut.state), 32'(ST_IDLE));
      rst = 1'b0;
      spi_bits(8'h55, 4, r0);
      spi_bits(8'h44, 8, r0);
      spi_bits(8'h66, 8, r0);
      spi_bits(8'h77, 4, r0);
      repeat (HALF) tick();
      spi_cs_n = 1'b1;
      repeat (60) tick();
      drain("post-rst");
      chk("post-rst addr", addr, 0);

      exp_wr.push_back({8'h10, 8'h99});
      frame(8'h10, 1, 8'h99, 8'h00, r_op, r_dm, r0, r1);
      drain("write after rst");

      chk("wr/rd overlap cycles", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
